// File: rtl/iter_divider_if.sv
// Issue/result handshake bundle for iter_divider.
// The master side issues operations and consumes results.
interface iter_divider_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [XLEN-1:0] in_dividend;
  logic [XLEN-1:0] in_divisor;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, in_op,
    output in_dividend, in_divisor,
    output out_ready,
    input  in_ready, out_valid,
    input  out_result
  );

  modport slave (
    input  in_valid, in_op,
    input  in_dividend, in_divisor,
    input  out_ready,
    output in_ready, out_valid,
    output out_result
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring RV32M divider using the shared adder.
// Macro DIV_FAST_SPECIAL_EN: early-out for div-by-zero/overflow.
module iter_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  iter_divider_if.slave   io,
  output logic            busy,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  output logic            add_sub,
  input  logic [XLEN-1:0] add_sum,
  input  logic            add_cout
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  state_t          state_n;
  logic [1:0]      op;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic            take;

  function automatic logic [XLEN-1:0] negate(
    input logic [XLEN-1:0] x
  );
    return ~x + XLEN'(1);
  endfunction

  logic            sgn_in;
  logic            neg_a_in;
  logic            neg_b_in;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  assign sgn_in   = ~io.in_op[0];
  assign neg_a_in = sgn_in & io.in_dividend[XLEN-1];
  assign neg_b_in = sgn_in & io.in_divisor[XLEN-1];
  assign mag_a    = neg_a_in ? negate(io.in_dividend)
                             : io.in_dividend;
  assign mag_b    = neg_b_in ? negate(io.in_divisor)
                             : io.in_divisor;

  logic special;
`ifdef DIV_FAST_SPECIAL_EN
  logic            spec_z;
  logic [XLEN-1:0] fast_res;
  assign spec_z  = (io.in_divisor == '0);
  assign special = spec_z
                 | (sgn_in
                    & (io.in_dividend == MIN)
                    & (&io.in_divisor));
  assign fast_res = io.in_op[1]
                  ? (spec_z ? io.in_dividend : '0)
                  : (spec_z ? '1 : MIN);
`else
  assign special = 1'b0;
`endif

  // Sign fix-up; a zero divisor overrides to the RISC-V values.
  logic            div0;
  logic            q_neg;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;

  assign div0  = (dvs == '0);
  assign q_neg = ~op[0] & (neg_a ^ neg_b) & ~div0;
  assign q_fin = div0  ? '1
               : q_neg ? negate(quot) : quot;
  assign r_fin = div0  ? dvd
               : neg_a ? negate(rem) : rem;

  assign io.in_ready   = (state == IDLE);
  assign io.out_valid  = (state == DONE);
  assign io.out_result = res;
  assign busy          = (state != IDLE);

  always_comb begin
    state_n = state;
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (io.in_valid) begin
          state_n = special ? DONE : CALC;
        end
      end
      CALC: begin
        add_a   = {rem[XLEN-2:0], quot[XLEN-1]};
        add_b   = dvs;
        add_sub = 1'b1;
        take    = add_cout | rem[XLEN-1];
        if (cnt == CNT_W'(XLEN-1)) begin
          state_n = SIGN;
        end
      end
      SIGN: state_n = DONE;
      DONE: begin
        if (io.out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op    <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      quot  <= '0;
      res   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (io.in_valid) begin
            op    <= io.in_op;
            neg_a <= neg_a_in;
            neg_b <= neg_b_in;
            dvd   <= io.in_dividend;
            dvs   <= mag_b;
            quot  <= mag_a;
            rem   <= '0;
            cnt   <= '0;
`ifdef DIV_FAST_SPECIAL_EN
            if (special) begin
              res <= fast_res;
            end
`endif
          end
        end
        CALC: begin
          rem  <= take ? add_sum : add_a;
          quot <= {quot[XLEN-2:0], take};
          cnt  <= cnt + CNT_W'(1);
        end
        SIGN: res <= op[1] ? r_fin : q_fin;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the execute stage.
- Runs a radix-2 restoring division, one step per clock, for 32 steps.
- Each step's trial subtraction is done by the core's shared 32-bit carry-lookahead adder. This block drives the adder's operands and subtract control, and consumes its sum and carry-out.
- Valid/ready handshakes on both the issue side and the result side.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, width of the step counter; must hold XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- in_dividend  in  32  rs1.
- in_divisor  in  32  rs2.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  32  quotient or remainder.
- busy  out  1  high in any state other than IDLE.
- add_a  out  32  adder operand d1.
- add_b  out  32  adder operand d2.
- add_sub  out  1  adder cin; 1 = subtract. The adder computes add_a + ~add_b + 1 when add_sub is 1.
- add_sum  in  32  adder sum (combinational return).
- add_cout  in  1  adder carry-out; when subtracting, 1 means add_a >= add_b (unsigned).

Behaviour:
- Reset values: state IDLE; in_ready 1; out_valid 0; busy 0; out_result 0; add_a, add_b, add_sub all 0; internal registers 0.
- A reset asserted in any state, including mid-CALC, returns the block to IDLE on the next edge and discards the operation. No result is produced.
- State IDLE:
  - in_ready = 1.
  - On in_valid, latch the op, the operand sign flags, and the operand magnitudes.
  - Magnitude = two's-complement negation via an internal incrementer, applied only when the op is signed and the operand MSB is 1.
  - Clear rem, clear cnt, set quot = |dividend|, go to CALC.
- State CALC (exactly 32 cycles):
  - add_a = {rem[30:0], quot[31]}, add_b = |divisor|, add_sub = 1.
  - take = add_cout | rem[31].
  - rem <= take ? add_sum : add_a.
  - quot <= {quot[30:0], take}.
  - cnt increments each cycle; after the step with cnt == 31, go to SIGN.
  - Outside CALC, add_a, add_b and add_sub are all 0.
- State SIGN:
  - Quotient is negated if the op is signed, the operand signs differ, and the divisor is non-zero.
  - Remainder is negated if the op is signed and the dividend is negative.
  - Divisor == 0 override: quotient = 0xFFFFFFFF, remainder = original dividend.
  - Select quotient for ops 0x and remainder for ops 1x, register it into out_result, go to DONE.
- State DONE:
  - out_valid = 1; out_result is held stable.
  - On out_ready, go to IDLE with out_valid = 0.
  - No new request is accepted while in DONE.
- Latency: the accept cycle is cycle 0, CALC occupies cycles 1–32, SIGN is cycle 33, and out_valid is first high in cycle 34.
- Overflow (0x80000000 DIV 0xFFFFFFFF) needs no special path: the algorithm yields quotient 0x80000000 and remainder 0.
- in_op, in_dividend and in_divisor are sampled only in the accept cycle; later changes have no effect.

Optional Feature:
- Macro: DIV_FAST_SPECIAL_EN.
- When defined:
  - In IDLE, a divisor of 0 or a signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF, signed op) skips CALC and SIGN.
  - The block goes directly to DONE with the RISC-V-specified result; out_valid is high in cycle 1.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - Overflow: quotient 0x80000000, remainder 0.
- When undefined: every operation takes the full 34-cycle path, with the divide-by-zero override applied in SIGN.

Test Plan:
- DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002. In both cases out_valid is first high exactly in cycle 34, and add_sub is high for 32 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- DIV 0xFFFFFFFB/0 -> 0xFFFFFFFF; REM 5/0 -> 0x00000005. Latency is 34 cycles without DIV_FAST_SPECIAL_EN and 1 cycle with it.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000, under both macro settings.
- DIVU 50/5 completes with out_ready held low for 5 cycles: out_valid and out_result = 0x0000000A stay stable, and in_ready stays 0 until the handshake completes.
- Start DIVU 1000/3 and assert rst in CALC cycle 10 -> the next cycle shows IDLE, in_ready 1, out_valid 0, busy 0, add_sub 0. A following REMU 1000/3 returns 0x00000001.
